// File: rtl/otp_ctrl_edn_arb_pack.sv
// otp_ctrl_edn_arb_pack: round-robin arbiter packing NumWords EDN words into one OutWidth entropy word.
// Optional OTP_EDN_FIPS_TRACK_EN: fips_o is the AND of the per-word EDN FIPS flags.
module otp_ctrl_edn_arb_pack #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned EdnWidth = 32,
  parameter int unsigned OutWidth = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   ack_o,
  output logic [OutWidth-1:0] data_o,
  output logic                edn_req_o,
  input  logic                edn_ack_i,
  input  logic [EdnWidth-1:0] edn_bus_i,
  input  logic                edn_fips_i,
  output logic                fips_o,
  output logic                fsm_err_o
);
  localparam int unsigned NumWords = OutWidth / EdnWidth;
  localparam int unsigned CntW     = $clog2(NumWords + 1);
  localparam int unsigned IdxW     = NumReq > 1 ? $clog2(NumReq) : 1;

  if (OutWidth == 0 || OutWidth % EdnWidth != 0) begin : g_bad_width
    $error("OutWidth must be a nonzero multiple of EdnWidth");
  end
  if (NumReq < 1) begin : g_bad_numreq
    $error("NumReq must be at least 1");
  end

  // Pairwise Hamming distance >= 3 between all encodings.
  typedef enum logic [4:0] {
    IdleSt    = 5'b00000,
    FetchSt   = 5'b00111,
    DeliverSt = 5'b11001,
    ErrorSt   = 5'b11110
  } state_e;

  state_e              state_d;
  logic [4:0]          state_q;
  logic [OutWidth-1:0] pack_q, pack_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     rr_q, rr_d, gnt_q, gnt_d, sel;
  logic                found;

  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!found && req_i[(int'(rr_q) + k) % int'(NumReq)]) begin
        found = 1'b1;
        sel   = IdxW'((int'(rr_q) + k) % int'(NumReq));
      end
    end
  end

  always_comb begin
    state_d   = ErrorSt;
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    ack_o     = '0;
    edn_req_o = 1'b0;
    fsm_err_o = 1'b0;
    case (state_q)
      IdleSt: begin
        state_d = |req_i ? FetchSt : IdleSt;
        gnt_d   = |req_i ? sel : gnt_q;
        cnt_d   = '0;
      end
      FetchSt: begin
        edn_req_o = 1'b1;
        state_d   = (edn_ack_i && cnt_q == CntW'(NumWords - 1)) ? DeliverSt : FetchSt;
        if (edn_ack_i) begin
          pack_d[int'(cnt_q)*EdnWidth +: EdnWidth] = edn_bus_i;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DeliverSt: begin
        ack_o   = req_i[gnt_q] ? (NumReq'(1) << gnt_q) : '0;
        state_d = IdleSt;
        pack_d  = '0;
        rr_d    = (int'(gnt_q) == int'(NumReq) - 1) ? '0 : gnt_q + 1'b1;
      end
      default: begin
        state_d   = ErrorSt;
        fsm_err_o = 1'b1;
      end
    endcase
  end

  assign data_o = |ack_o ? pack_q : '0;

`ifdef OTP_EDN_FIPS_TRACK_EN
  logic fips_q, fips_d;
  always_comb begin
    fips_d = fips_q;
    if (state_q == IdleSt && |req_i) fips_d = 1'b1;
    else if (state_q == FetchSt && edn_ack_i) fips_d = fips_q & edn_fips_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fips_q <= 1'b1;
    else fips_q <= fips_d;
  end
  assign fips_o = |ack_o & fips_q;
`else
  logic unused_fips;
  assign unused_fips = edn_fips_i;
  assign fips_o      = |ack_o;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IdleSt;
      pack_q  <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule
